// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position scheduler: one motion tick per frame at the blanking line,
// edge bounce, and host position loads that only take effect on a frame boundary.
module sprite_motion_ctrl #(
   parameter int unsigned WIDTH    = 256,
   parameter int unsigned HEIGHT   = 256,
   parameter int unsigned SCREEN_W = 1024,
   parameter int unsigned SCREEN_H = 768,
   parameter int unsigned SPEED    = 2
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        pause_in,
   input  logic        load_valid_in,
   input  logic [10:0] load_x_in,
   input  logic [9:0]  load_y_in,
   output logic        load_ready_out,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        dir_x_out,
   output logic        dir_y_out,
   output logic [15:0] frame_count_out,
   output logic        bounce_out
);

   localparam logic [10:0] MaxX     = 11'(SCREEN_W - WIDTH);
   localparam logic [9:0]  MaxY     = 10'(SCREEN_H - HEIGHT);
   localparam logic [10:0] StepX    = 11'(SPEED);
   localparam logic [9:0]  StepY    = 10'(SPEED);
   localparam logic [9:0]  TickLine = 10'(SCREEN_H);

   typedef enum logic [1:0] {StRun, StPaused, StLoadPend} state_e;

   state_e      state_q, state_d;
   logic        cond, cond_q, tick, accept;
   logic [10:0] x_q, x_d, hold_x_q, hold_x_d;
   logic [9:0]  y_q, y_d, hold_y_q, hold_y_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic        bounce_q, bounce_d;
   logic [15:0] frame_q, frame_d;

   // Edge-detect the blanking position so a stalled raster still yields a single tick.
   assign cond   = (hcount_in == 11'd0) && (vcount_in == TickLine);
   assign tick   = cond && !cond_q;
   assign accept = load_valid_in && load_ready_out;

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (accept)                state_d = StLoadPend;
            else if (tick && pause_in) state_d = StPaused;
         end
         StPaused: begin
            if (accept)         state_d = StLoadPend;
            else if (!pause_in) state_d = StRun;
         end
         StLoadPend: begin
            if (tick) state_d = pause_in ? StPaused : StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      load_ready_out = (state_q != StLoadPend);
   end

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      hold_x_d = hold_x_q;
      hold_y_d = hold_y_q;
      bounce_d = 1'b0;
      frame_d  = tick ? frame_q + 16'd1 : frame_q;
      if (accept) begin
         hold_x_d = load_x_in;
         hold_y_d = load_y_in;
      end
      if (tick) begin
         if (state_q == StLoadPend) begin
            x_d = (hold_x_q > MaxX) ? MaxX : hold_x_q;
            y_d = (hold_y_q > MaxY) ? MaxY : hold_y_q;
         end else if (!pause_in) begin
            if (!dir_x_q) begin
               if (12'(x_q) + 12'(SPEED) >= 12'(MaxX)) begin
                  x_d = MaxX; dir_x_d = 1'b1; bounce_d = 1'b1;
               end else begin
                  x_d = x_q + StepX;
               end
            end else if (12'(x_q) <= 12'(SPEED)) begin
               x_d = '0; dir_x_d = 1'b0; bounce_d = 1'b1;
            end else begin
               x_d = x_q - StepX;
            end
            if (!dir_y_q) begin
               if (12'(y_q) + 12'(SPEED) >= 12'(MaxY)) begin
                  y_d = MaxY; dir_y_d = 1'b1; bounce_d = 1'b1;
               end else begin
                  y_d = y_q + StepY;
               end
            end else if (12'(y_q) <= 12'(SPEED)) begin
               y_d = '0; dir_y_d = 1'b0; bounce_d = 1'b1;
            end else begin
               y_d = y_q - StepY;
            end
         end
      end
   end

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         cond_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         dir_x_q  <= 1'b0;
         dir_y_q  <= 1'b0;
         hold_x_q <= '0;
         hold_y_q <= '0;
         bounce_q <= 1'b0;
         frame_q  <= '0;
      end else begin
         cond_q   <= cond;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         hold_x_q <= hold_x_d;
         hold_y_q <= hold_y_d;
         bounce_q <= bounce_d;
         frame_q  <= frame_d;
      end
   end

   assign x_out           = x_q;
   assign y_out           = y_q;
   assign dir_x_out       = dir_x_q;
   assign dir_y_out       = dir_y_q;
   assign frame_count_out = frame_q;
   assign bounce_out      = bounce_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: frame table with fixed expectations, hand-built corner
// sequences, and randomized traffic checked against an integer reference model.
module tb_sprite_motion_ctrl;

   localparam int SCREEN_H = 768;
   localparam int MAXX     = 768;
   localparam int MAXY     = 512;
   localparam int SPD      = 2;

   logic        clk, rst;
   logic [10:0] hcount, lx;
   logic [9:0]  vcount, ly;
   logic        pause, lv;
   logic        ready, dx, dy, bounce;
   logic [10:0] x;
   logic [9:0]  y;
   logic [15:0] fc;

   int n_vec, n_miss;

   // Reference model state
   int mx, my, mdx, mdy, mfc, mb, mready, mpend, mhx, mhy, mprev;

   typedef struct {
      bit pause; bit load; int lx; int ly;
      int ex; int ey; int edx; int edy; int eb; int efc;
   } frame_t;

   frame_t tbl[19];

   sprite_motion_ctrl dut (
      .pixel_clk_in   (clk),
      .rst_in         (rst),
      .hcount_in      (hcount),
      .vcount_in      (vcount),
      .pause_in       (pause),
      .load_valid_in  (lv),
      .load_x_in      (lx),
      .load_y_in      (ly),
      .load_ready_out (ready),
      .x_out          (x),
      .y_out          (y),
      .dir_x_out      (dx),
      .dir_y_out      (dy),
      .frame_count_out(fc),
      .bounce_out     (bounce)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mx = 0; my = 0; mdx = 0; mdy = 0; mfc = 0; mb = 0;
      mready = 1; mpend = 0; mhx = 0; mhy = 0; mprev = 0;
   endtask

   // Signed step, then clamp into [0, lim]; touching either end reflects.
   task automatic move_axis(inout int p, inout int d, input int lim, output bit b);
      int np;
      np = p + (d != 0 ? -SPD : SPD);
      b  = 1'b0;
      if (np <= 0) begin
         p = 0; d = 0; b = 1'b1;
      end else if (np >= lim) begin
         p = lim; d = 1; b = 1'b1;
      end else begin
         p = np;
      end
   endtask

   task automatic model_edge();
      bit cond, tk, acc, b1, b2;
      cond  = (int'(hcount) == 0) && (int'(vcount) == SCREEN_H);
      tk    = cond && (mprev == 0);
      mprev = cond ? 1 : 0;
      acc   = lv && (mready != 0);
      mb    = 0;
      if (tk) begin
         mfc = (mfc + 1) % 65536;
         if (mpend != 0) begin
            mx = (mhx > MAXX) ? MAXX : mhx;
            my = (mhy > MAXY) ? MAXY : mhy;
            mpend = 0; mready = 1;
         end else if (!pause) begin
            move_axis(mx, mdx, MAXX, b1);
            move_axis(my, mdy, MAXY, b2);
            mb = (b1 || b2) ? 1 : 0;
         end
      end
      if (acc) begin
         mhx = int'(lx); mhy = int'(ly); mpend = 1; mready = 0;
      end
   endtask

   task automatic compare_model();
      chk("model_x", int'(x), mx);
      chk("model_y", int'(y), my);
      chk("model_dir_x", int'(dx), mdx);
      chk("model_dir_y", int'(dy), mdy);
      chk("model_frame_count", int'(fc), mfc);
      chk("model_bounce", int'(bounce), mb);
      chk("model_load_ready", int'(ready), mready);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_dir_x"}, int'(dx), 0);
      chk({tag, "_dir_y"}, int'(dy), 0);
      chk({tag, "_frame_count"}, int'(fc), 0);
      chk({tag, "_bounce"}, int'(bounce), 0);
      chk({tag, "_load_ready"}, int'(ready), 1);
   endtask

   task automatic run_frame(input int idx, input frame_t r);
      string t;
      t = $sformatf("frame%0d", idx);
      hcount = 11'd5; vcount = 10'd0; pause = r.pause;
      lv = r.load; lx = 11'(r.lx); ly = 10'(r.ly);
      step();
      lv = 1'b0;
      if (r.load) chk({t, "_ready_after_accept"}, int'(ready), 0);
      step();
      hcount = 11'd0; vcount = 10'(SCREEN_H);
      step();
      chk({t, "_x"}, int'(x), r.ex);
      chk({t, "_y"}, int'(y), r.ey);
      chk({t, "_dir_x"}, int'(dx), r.edx);
      chk({t, "_dir_y"}, int'(dy), r.edy);
      chk({t, "_bounce"}, int'(bounce), r.eb);
      chk({t, "_frame_count"}, int'(fc), r.efc);
      chk({t, "_ready_after_tick"}, int'(ready), 1);
      hcount = 11'd1;
      step();
      chk({t, "_bounce_cleared"}, int'(bounce), 0);
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      tbl[0]  = '{0, 0, 0, 0, 2, 2, 0, 0, 0, 1};
      tbl[1]  = '{0, 0, 0, 0, 4, 4, 0, 0, 0, 2};
      tbl[2]  = '{0, 0, 0, 0, 6, 6, 0, 0, 0, 3};
      tbl[3]  = '{0, 1, 760, 508, 760, 508, 0, 0, 0, 4};
      tbl[4]  = '{0, 0, 0, 0, 762, 510, 0, 0, 0, 5};
      tbl[5]  = '{0, 0, 0, 0, 764, 512, 0, 1, 1, 6};
      tbl[6]  = '{0, 0, 0, 0, 766, 510, 0, 1, 0, 7};
      tbl[7]  = '{0, 0, 0, 0, 768, 508, 1, 1, 1, 8};
      tbl[8]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 9};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 10};
      tbl[10] = '{0, 1, 2000, 900, 768, 512, 0, 0, 0, 11};
      tbl[11] = '{0, 0, 0, 0, 768, 512, 1, 1, 1, 12};
      tbl[12] = '{1, 0, 0, 0, 768, 512, 1, 1, 0, 13};
      tbl[13] = '{1, 1, 100, 100, 100, 100, 1, 1, 0, 14};
      tbl[14] = '{1, 0, 0, 0, 100, 100, 1, 1, 0, 15};
      tbl[15] = '{1, 0, 0, 0, 100, 100, 1, 1, 0, 16};
      tbl[16] = '{1, 0, 0, 0, 100, 100, 1, 1, 0, 17};
      tbl[17] = '{1, 0, 0, 0, 100, 100, 1, 1, 0, 18};
      tbl[18] = '{0, 0, 0, 0, 98, 98, 1, 1, 0, 19};

      rst = 1'b1; hcount = 11'd5; vcount = 10'd0; pause = 1'b0;
      lv = 1'b0; lx = '0; ly = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b0;

      foreach (tbl[i]) run_frame(i, tbl[i]);

      // Raster stalled on the tick position: only one increment.
      hcount = 11'd0; vcount = 10'(SCREEN_H);
      repeat (50) step();
      chk("stall_frame_count", int'(fc), 20);
      chk("stall_x", int'(x), 96);

      // Reset asserted mid-hold clears everything before the next edge.
      lv = 1'b1; lx = 11'd50; ly = 10'd50;
      #1 rst = 1'b1;
      model_reset();
      #1;
      chk_reset_state("midhold_reset");
      lv = 1'b0;
      #1 rst = 1'b0;
      step();
      chk("post_reset_frame_count", int'(fc), 1);
      chk("post_reset_x", int'(x), 2);

      // Load accepted on a tick cycle: that tick moves normally, the next one applies it.
      hcount = 11'd1;
      step();
      hcount = 11'd0; lv = 1'b1; lx = 11'd300; ly = 10'd200;
      step();
      chk("tick_load_motion_x", int'(x), 4);
      chk("tick_load_ready", int'(ready), 0);
      lv = 1'b0; hcount = 11'd1;
      step();
      hcount = 11'd0;
      step();
      chk("tick_load_applied_x", int'(x), 300);
      chk("tick_load_applied_y", int'(y), 200);
      chk("tick_load_ready_back", int'(ready), 1);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            hcount = 11'd0; vcount = 10'(SCREEN_H);
         end else begin
            hcount = 11'($urandom_range(0, 2047));
            vcount = 10'($urandom_range(0, 1023));
         end
         pause = ($urandom_range(0, 3) == 0);
         lv    = ($urandom_range(0, 39) == 0);
         lx    = 11'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 800)
                                                 : $urandom_range(0, 2047));
         ly    = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 299) == 0) begin
            #1 rst = 1'b1;
            model_reset();
            #1;
            compare_model();
            #1 rst = 1'b0;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
